// File: rtl/mbist_march_ctrl.sv
// ============================================================================
// Module  : mbist_march_ctrl
// Purpose : March C- BIST sequencer for a single-port memory with registered
//           wdata and a 2-cycle read latency; reports pass/fail status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CAPACITY   = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [7:0]            fail_count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_GAP   = 3'd1;
    localparam logic [2:0] c_ST_RD    = 3'd2;
    localparam logic [2:0] c_ST_WR    = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(CAPACITY);

    logic [2:0]            r_state;
    logic [2:0]            r_elem;
    logic                  r_drain;

    logic                  r_p0_vld, r_p1_vld;
    logic [DATA_WIDTH-1:0] r_p0_exp, r_p1_exp;
    logic [ADDR_WIDTH-1:0] r_p0_addr, r_p1_addr;
    logic [2:0]            r_p0_elem, r_p1_elem;

    logic [2:0]            w_nstate;
    logic [2:0]            w_nelem;
    logic [ADDR_WIDTH-1:0] w_naddr;
    logic                  w_down, w_has_rd, w_has_wr, w_last, w_start_ok;
    logic [ADDR_WIDTH-1:0] w_step_addr, w_next_first;
    logic [2:0]            w_elem_inc;
    logic [DATA_WIDTH-1:0] w_rd_exp;

    assign w_down       = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_has_rd     = (r_elem != 3'd0);
    assign w_has_wr     = (r_elem != 3'd5);
    assign w_last       = w_down ? (mem_address == '0) : (mem_address == c_LAST_ADDR);
    assign w_step_addr  = w_down ? (mem_address - 1'b1) : (mem_address + 1'b1);
    assign w_elem_inc   = r_elem + 3'd1;
    assign w_next_first = ((w_elem_inc == 3'd3) || (w_elem_inc == 3'd4)) ? c_LAST_ADDR : '0;
    assign w_rd_exp     = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? '1 : '0;
    // DONE keeps busy for one cycle while done is being raised; start is ignored there
    assign w_start_ok   = start && ((r_state == c_ST_IDLE) || ((r_state == c_ST_DONE) && !busy));

    always_comb begin
        w_nstate = r_state;
        w_nelem  = r_elem;
        w_naddr  = mem_address;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_start_ok) begin
                    w_nstate = c_ST_GAP;
                    w_nelem  = 3'd0;
                    w_naddr  = '0;
                end
            end
            c_ST_GAP: w_nstate = w_has_rd ? c_ST_RD : c_ST_WR;
            c_ST_RD: begin
                if (w_has_wr) begin
                    w_nstate = c_ST_WR;
                end else if (w_last) begin
                    w_nstate = c_ST_DRAIN;
                end else begin
                    w_naddr = w_step_addr;
                end
            end
            c_ST_WR: begin
                if (w_last) begin
                    w_nstate = c_ST_GAP;
                    w_nelem  = w_elem_inc;
                    w_naddr  = w_next_first;
                end else begin
                    w_nstate = w_has_rd ? c_ST_RD : c_ST_WR;
                    w_naddr  = w_step_addr;
                end
            end
            c_ST_DRAIN: if (r_drain) w_nstate = c_ST_DONE;
            default:    w_nstate = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_elem         <= 3'd0;
            r_drain        <= 1'b0;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_addr      <= '0;
            fail_element   <= 3'd0;
            fail_count     <= 8'd0;
            r_p0_vld       <= 1'b0;
            r_p1_vld       <= 1'b0;
            r_p0_exp       <= '0;
            r_p1_exp       <= '0;
            r_p0_addr      <= '0;
            r_p1_addr      <= '0;
            r_p0_elem      <= 3'd0;
            r_p1_elem      <= 3'd0;
        end else begin
            r_state        <= w_nstate;
            r_elem         <= w_nelem;
            mem_address    <= w_naddr;
            mem_write_read <= (w_nstate == c_ST_WR);
            r_drain        <= (r_state == c_ST_DRAIN) ? ~r_drain : 1'b0;
            // Background is fixed for the whole element so the memory's wdata register is always valid
            if (w_nstate == c_ST_GAP) begin
                mem_wdata <= ((w_nelem == 3'd1) || (w_nelem == 3'd3)) ? '1 : '0;
            end

            r_p0_vld  <= (r_state == c_ST_RD);
            r_p0_exp  <= w_rd_exp;
            r_p0_addr <= mem_address;
            r_p0_elem <= r_elem;
            r_p1_vld  <= r_p0_vld;
            r_p1_exp  <= r_p0_exp;
            r_p1_addr <= r_p0_addr;
            r_p1_elem <= r_p0_elem;

            if (w_start_ok) begin
                busy         <= 1'b1;
                done         <= 1'b0;
                fail         <= 1'b0;
                fail_addr    <= '0;
                fail_element <= 3'd0;
                fail_count   <= 8'd0;
            end else begin
                if ((r_state == c_ST_DONE) && busy) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (r_p1_vld && (mem_rdata != r_p1_exp)) begin
                    if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                    if (!fail) begin
                        fail         <= 1'b1;
                        fail_addr    <= r_p1_addr;
                        fail_element <= r_p1_elem;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mbist_march_ctrl.sv
// ============================================================================
// Module  : tb_mbist_march_ctrl
// Purpose : Directed bench for mbist_march_ctrl with a faulty-memory stand-in
//           and an algorithm-level March C- reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbist_march_ctrl;

    localparam int c_N    = 64;
    localparam int c_NOPS = 10 * c_N + 6;
    localparam int c_LAT  = 10 * c_N + 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mem_write_read;
    logic [5:0] mem_address;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy, done, fail;
    logic [5:0] fail_addr;
    logic [2:0] fail_element;
    logic [7:0] fail_count;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .CAPACITY(63)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_write_read(mem_write_read), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_element(fail_element), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int fault_mode = 0;
    int cyc = 0;
    logic track = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // 0: fault-free, 1: word 5 bit0 stuck-at-0, 2: word 10 always reads 8'hAA
    function automatic logic [7:0] faulty(input int fm, input logic [5:0] a, input logic [7:0] v);
        if (fm == 1 && a == 6'd5) return v & 8'hFE;
        if (fm == 2 && a == 6'd10) return 8'hAA;
        return v;
    endfunction

    // Memory stand-in: wdata registered one cycle, reads 2 cycles latency
    logic [7:0] mem [64];
    logic [7:0] wdata_q, rdata_q;
    logic [5:0] raddr_q;
    always @(posedge clk) begin
        wdata_q <= mem_wdata;
        raddr_q <= mem_address;
        rdata_q <= faulty(fault_mode, raddr_q, mem[raddr_q]);
        if (mem_write_read) mem[mem_address] <= wdata_q;
    end
    assign mem_rdata = rdata_q;

    // Expected operation stream, indexed by cycle after the start edge
    int op_we [700];
    int op_addr [700];
    int op_wd [700];
    int op_exp [700];
    int exp_fail, exp_faddr, exp_felem, exp_fcnt;

    function automatic void build_ops();
        int idx = 1;
        int wbg [6] = '{0, 255, 0, 255, 0, 0};
        int rbg [6] = '{0, 0, 255, 0, 255, 0};
        for (int e = 0; e < 6; e++) begin
            bit dn = (e == 3 || e == 4);
            op_we[idx] = 0; op_addr[idx] = dn ? c_N - 1 : 0; op_wd[idx] = wbg[e]; idx++;
            for (int i = 0; i < c_N; i++) begin
                int a = dn ? c_N - 1 - i : i;
                if (e != 0) begin
                    op_we[idx] = 0; op_addr[idx] = a; op_wd[idx] = wbg[e]; op_exp[idx] = rbg[e]; idx++;
                end
                if (e != 5) begin
                    op_we[idx] = 1; op_addr[idx] = a; op_wd[idx] = wbg[e]; idx++;
                end
            end
        end
    endfunction

    function automatic void predict(input int fm);
        logic [7:0] img [64];
        exp_fail = 0; exp_faddr = 0; exp_felem = 0; exp_fcnt = 0;
        for (int j = 1; j <= c_NOPS; j++) begin
            int el = (j <= 65) ? 0 : (j <= 194) ? 1 : (j <= 323) ? 2 : (j <= 452) ? 3 : (j <= 581) ? 4 : 5;
            bit gap = (j == 1 || j == 66 || j == 195 || j == 324 || j == 453 || j == 582);
            if (gap) continue;
            if (op_we[j] == 1) img[op_addr[j]] = 8'(op_wd[j]);
            else if (faulty(fm, 6'(op_addr[j]), img[op_addr[j]]) != 8'(op_exp[j])) begin
                if (exp_fail == 0) begin
                    exp_fail = 1; exp_faddr = op_addr[j]; exp_felem = el;
                end
                if (exp_fcnt < 255) exp_fcnt++;
            end
        end
    endfunction

    int rec_we [700];
    int rec_addr [700];
    int rec_wd [700];

    // Per-cycle comparison against the expected operation stream
    always @(negedge clk) begin
        if (!track) cyc = 0;
        else begin
            cyc++;
            if (cyc < 700) begin
                rec_we[cyc] = int'(mem_write_read);
                rec_addr[cyc] = int'(mem_address);
                rec_wd[cyc] = int'(mem_wdata);
            end
            if (cyc == 1) begin
                chk("clear_fail", fail, 0);
                chk("clear_count", fail_count, 0);
                chk("clear_done", done, 0);
            end
            if (cyc <= c_NOPS) begin
                chk("op_we", mem_write_read, op_we[cyc]);
                chk("op_addr", mem_address, op_addr[cyc]);
                if (op_we[cyc] == 1) chk("op_wdata", mem_wdata, op_wd[cyc]);
            end else begin
                chk("idle_we", mem_write_read, 0);
            end
            chk("busy", busy, (cyc - 1) < c_LAT);
            chk("done", done, (cyc - 1) >= c_LAT);
        end
    end

    task automatic run(input int fm, input int repulse_at, input int rst_at);
        bit aborted = 0;
        fault_mode = fm;
        predict(fm);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; track = 1'b1;
        for (int k = 1; k <= c_LAT + 5; k++) begin
            @(posedge clk); #1;
            start = (k == repulse_at);
            if (k == rst_at) begin
                rst = 1'b1; #1;
                chk("rst_busy", busy, 0);
                chk("rst_we", mem_write_read, 0);
                chk("rst_addr", mem_address, 0);
                chk("rst_fail", fail, 0);
                chk("rst_done", done, 0);
                chk("rst_wdata", mem_wdata, 0);
                track = 1'b0;
                #2 rst = 1'b0;
                aborted = 1;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            chk("end_fail", fail, exp_fail);
            chk("end_faddr", fail_addr, exp_faddr);
            chk("end_felem", fail_element, exp_felem);
            chk("end_fcount", fail_count, exp_fcnt);
            track = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        build_ops();
        // Pin the reference stream: E3 starts at word 63 with a read, then writes all-ones
        chk("model_e3_addr", op_addr[325], 63);
        chk("model_e3_rd", op_we[325], 0);
        chk("model_e3_wd", op_wd[326], 8'hFF);

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fail", fail, 0);
        chk("reset_faddr", fail_addr, 0);
        chk("reset_felem", fail_element, 0);
        chk("reset_fcount", fail_count, 0);
        chk("reset_we", mem_write_read, 0);
        @(negedge clk); rst = 1'b0;

        // T1 fault-free, T3 address walk during E3
        run(0, 0, 0);
        chk("t1_fail", fail, 0);
        chk("t1_count", fail_count, 0);
        chk("t3_first_addr", rec_addr[325], 63);
        chk("t3_first_rd", rec_we[325], 0);
        chk("t3_first_wr", rec_we[326], 1);
        chk("t3_wdata", rec_wd[326], 8'hFF);
        chk("t3_mid_addr", rec_addr[389], 31);
        chk("t3_last_addr", rec_addr[452], 0);
        chk("t3_last_wr", rec_we[452], 1);

        // T2 stuck-at-0
        run(1, 0, 0);
        chk("t2_fail", fail, 1);
        chk("t2_addr", fail_addr, 5);
        chk("t2_elem", fail_element, 2);
        chk("t2_count", fail_count, 2);

        // T6 word reads 8'hAA
        run(2, 0, 0);
        chk("t6_addr", fail_addr, 10);
        chk("t6_elem", fail_element, 1);
        chk("t6_count", fail_count, 5);

        // T5 start re-pulse while busy; new start clears previous failing status
        run(0, 100, 0);
        chk("t5_fail", fail, 0);
        chk("t5_count", fail_count, 0);

        // T4 reset mid-run, then a full run
        run(0, 0, 300);
        run(0, 0, 0);
        chk("t4_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
